// File: rtl/i2c_pkg.sv
//------------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C register sequencer.
//   state_e         : transaction state of the sequencer
//   ACK / NACK      : values driven on the ack output
//   GCALL_RESET_CMD : general-call data byte that clears the register pointer
//   IDLE_TX_BYTE    : byte returned for reads that are not addressed to us
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PTR,
        WR,
        RD,
        IGNORE,
        GCALL
    } state_e;

    localparam logic       ACK             = 1'b1;
    localparam logic       NACK            = 1'b0;
    localparam logic [7:0] GCALL_RESET_CMD = 8'h06;
    localparam logic [7:0] IDLE_TX_BYTE    = 8'hFF;

endpackage

// File: rtl/i2c_rf_arbiter.sv
//------------------------------------------------------------------------------
// i2c_rf_arbiter
// Fixed-priority arbiter in front of the register file. The I2C side wins any
// cycle in which it strobes rf_we/rf_re; otherwise a pending local request is
// granted in the same cycle and drives the register-file port.
//   clk, rst                     : clock, asynchronous active-high reset
//   i2c_we_i/re_i/addr_i/wdata_i : registered access from the sequencer
//   loc_req_i/we_i/addr_i/wdata_i: local requester (held until granted)
//   rf_rdata_i                   : register-file read data (1 cycle after rf_re)
//   rf_addr_o/we_o/re_o/wdata_o  : register-file port
//   loc_gnt_o                    : one-cycle grant pulse
//   loc_rvalid_o / loc_rdata_o   : local read return, 1 cycle after the grant
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_rf_arbiter #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i2c_we_i,
    input  logic          i2c_re_i,
    input  logic [PW-1:0] i2c_addr_i,
    input  logic [7:0]    i2c_wdata_i,
    input  logic          loc_req_i,
    input  logic          loc_we_i,
    input  logic [PW-1:0] loc_addr_i,
    input  logic [7:0]    loc_wdata_i,
    input  logic [7:0]    rf_rdata_i,
    output logic [PW-1:0] rf_addr_o,
    output logic          rf_we_o,
    output logic          rf_re_o,
    output logic [7:0]    rf_wdata_o,
    output logic          loc_gnt_o,
    output logic          loc_rvalid_o,
    output logic [7:0]    loc_rdata_o
);

    logic i2c_busy;
    logic loc_rvalid_q;

    assign i2c_busy   = i2c_we_i | i2c_re_i;
    assign loc_gnt_o  = loc_req_i & ~i2c_busy;

    assign rf_we_o    = i2c_we_i | (loc_gnt_o & loc_we_i);
    assign rf_re_o    = i2c_re_i | (loc_gnt_o & ~loc_we_i);
    // When idle the port rests on the sequencer's registered address/data.
    assign rf_addr_o  = loc_gnt_o ? loc_addr_i  : i2c_addr_i;
    assign rf_wdata_o = loc_gnt_o ? loc_wdata_i : i2c_wdata_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loc_rvalid_q <= 1'b0;
        end else begin
            loc_rvalid_q <= loc_gnt_o & ~loc_we_i;
        end
    end

    // The register file's registered read lands exactly in the rvalid cycle.
    assign loc_rvalid_o = loc_rvalid_q;
    assign loc_rdata_o  = loc_rvalid_q ? rf_rdata_i : 8'h00;

endmodule

// File: rtl/i2c_reg_sequencer.sv
//------------------------------------------------------------------------------
// i2c_reg_sequencer
// Transaction controller between the I2C slave byte engine and the register
// file: decodes the address and pointer bytes, sequences writes/reads with
// pointer auto-increment, drives per-byte ACK/NACK and shares the register
// file with a local requester through i2c_rf_arbiter.
//   bus_start/bus_stop/rx_valid/rx_data : byte-engine events
//   ack_valid/ack                       : per-byte response, 1 cycle after rx_valid
//   tx_req -> tx_valid/tx_data          : read byte, 2 cycles after tx_req
//   rf_*                                : register-file port
//   loc_*                               : local requester
// Optional feature macro: I2C_GENERAL_CALL_EN (general-call address 8'h00,
// data byte 8'h06 clears the pointer).
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_reg_sequencer
    import i2c_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter logic [6:0]  DEV_ADDR = 7'h2A,
    localparam int         PW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bus_start,
    input  logic          bus_stop,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          ack_valid,
    output logic          ack,
    input  logic          tx_req,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    output logic [PW-1:0] rf_addr,
    output logic          rf_we,
    output logic          rf_re,
    output logic [7:0]    rf_wdata,
    input  logic [7:0]    rf_rdata,
    input  logic          loc_req,
    input  logic          loc_we,
    input  logic [PW-1:0] loc_addr,
    input  logic [7:0]    loc_wdata,
    output logic          loc_gnt,
    output logic          loc_rvalid,
    output logic [7:0]    loc_rdata
);

    localparam logic [8:0]    NUM_REGS_W = 9'(NUM_REGS);
    localparam logic [PW-1:0] LAST_PTR   = PW'(NUM_REGS - 1);

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    state_e        state_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] i2c_addr_q;
    logic [7:0]    i2c_wdata_q;
    logic          i2c_we_q;
    logic          i2c_re_q;
    logic          ack_valid_q;
    logic          ack_q;
    logic          rd_s1_q;      // real register read in flight
    logic          ff_s1_q;      // unaddressed read in flight (answers 8'hFF)
    logic          tx_valid_q;
    logic          tx_src_rf_q;
    logic [7:0]    tx_hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            i2c_addr_q  <= '0;
            i2c_wdata_q <= 8'h00;
            i2c_we_q    <= 1'b0;
            i2c_re_q    <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            rd_s1_q     <= 1'b0;
            ff_s1_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_src_rf_q <= 1'b0;
            tx_hold_q   <= 8'h00;
        end else begin
            ack_valid_q <= 1'b0;
            i2c_we_q    <= 1'b0;
            i2c_re_q    <= 1'b0;
            rd_s1_q     <= 1'b0;
            ff_s1_q     <= 1'b0;

            // Second read stage: data arrives from the register file now.
            tx_valid_q  <= rd_s1_q | ff_s1_q;
            tx_src_rf_q <= rd_s1_q;
            if (tx_valid_q) begin
                tx_hold_q <= tx_data;
            end
            if (rd_s1_q) begin
                ptr_q <= ptr_next(ptr_q);
            end

            if (rx_valid) begin
                ack_valid_q <= 1'b1;
                ack_q       <= NACK;
                case (state_q)
                    ADDR: begin
                        if (rx_data[7:1] == DEV_ADDR) begin
                            ack_q   <= ACK;
                            state_q <= rx_data[0] ? RD : PTR;
`ifdef I2C_GENERAL_CALL_EN
                        end else if (rx_data == 8'h00) begin
                            ack_q   <= ACK;
                            state_q <= GCALL;
`endif
                        end else begin
                            state_q <= IGNORE;
                        end
                    end
                    PTR: begin
                        if ({1'b0, rx_data} < NUM_REGS_W) begin
                            ptr_q   <= rx_data[PW-1:0];
                            ack_q   <= ACK;
                            state_q <= WR;
                        end else begin
                            state_q <= IGNORE;
                        end
                    end
                    WR: begin
                        i2c_we_q    <= 1'b1;
                        i2c_addr_q  <= ptr_q;
                        i2c_wdata_q <= rx_data;
                        ack_q       <= ACK;
                        ptr_q       <= ptr_next(ptr_q);
                    end
`ifdef I2C_GENERAL_CALL_EN
                    GCALL: begin
                        ack_q <= ACK;
                        if (rx_data == GCALL_RESET_CMD) begin
                            ptr_q <= '0;
                        end
                    end
`endif
                    default: ;  // IDLE, RD, IGNORE: NACK
                endcase
            end

            if (tx_req) begin
                if (state_q == RD) begin
                    i2c_re_q   <= 1'b1;
                    i2c_addr_q <= ptr_q;
                    rd_s1_q    <= 1'b1;
                end else begin
                    ff_s1_q    <= 1'b1;
                end
            end

            // Bus conditions override any byte-driven transition.
            if (bus_stop) begin
                state_q <= IDLE;
            end else if (bus_start) begin
                state_q <= ADDR;
            end
        end
    end

    assign ack_valid = ack_valid_q;
    assign ack       = ack_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_valid_q ? (tx_src_rf_q ? rf_rdata : IDLE_TX_BYTE) : tx_hold_q;

    i2c_rf_arbiter #(
        .PW (PW)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .i2c_we_i     (i2c_we_q),
        .i2c_re_i     (i2c_re_q),
        .i2c_addr_i   (i2c_addr_q),
        .i2c_wdata_i  (i2c_wdata_q),
        .loc_req_i    (loc_req),
        .loc_we_i     (loc_we),
        .loc_addr_i   (loc_addr),
        .loc_wdata_i  (loc_wdata),
        .rf_rdata_i   (rf_rdata),
        .rf_addr_o    (rf_addr),
        .rf_we_o      (rf_we),
        .rf_re_o      (rf_re),
        .rf_wdata_o   (rf_wdata),
        .loc_gnt_o    (loc_gnt),
        .loc_rvalid_o (loc_rvalid),
        .loc_rdata_o  (loc_rdata)
    );

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
`timescale 1ns/1ps
module tb_i2c_reg_sequencer;

    localparam int NR = 16;
    localparam int PW = 4;
`ifdef I2C_GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    // Reference-model modes (what the slave expects next).
    localparam int M_IDLE = 0, M_ADDR = 1, M_PTR = 2, M_WR = 3, M_RD = 4, M_IGN = 5, M_GC = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bus_start = 1'b0, bus_stop = 1'b0, rx_valid = 1'b0, tx_req = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          ack_valid, ack, tx_valid;
    logic [7:0]    tx_data;
    logic [PW-1:0] rf_addr;
    logic          rf_we, rf_re;
    logic [7:0]    rf_wdata;
    logic [7:0]    rf_rdata;
    logic          loc_req = 1'b0, loc_we = 1'b0;
    logic [PW-1:0] loc_addr = '0;
    logic [7:0]    loc_wdata = 8'h00;
    logic          loc_gnt, loc_rvalid;
    logic [7:0]    loc_rdata;

    always #5 clk = ~clk;

    i2c_reg_sequencer dut (
        .clk(clk), .rst(rst), .bus_start(bus_start), .bus_stop(bus_stop),
        .rx_valid(rx_valid), .rx_data(rx_data), .ack_valid(ack_valid), .ack(ack),
        .tx_req(tx_req), .tx_valid(tx_valid), .tx_data(tx_data),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_re(rf_re), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr),
        .loc_wdata(loc_wdata), .loc_gnt(loc_gnt), .loc_rvalid(loc_rvalid), .loc_rdata(loc_rdata)
    );

    // Register file attached to the DUT (environment, registered read).
    logic [7:0] mem [NR];
    always @(posedge clk) begin
        if (rf_we) mem[rf_addr] <= rf_wdata;
        if (rf_re) rf_rdata <= mem[rf_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct { logic [7:0] val; int cyc; } exp_t;
    exp_t ack_exp[$];
    exp_t tx_exp[$];
    exp_t loc_exp[$];
    int   we_seen = 0;
    int   we_exp  = 0;

    // ---------------- reference model ----------------
    int         mode = M_IDLE;
    logic [3:0] mptr = 4'd0;
    logic [7:0] gold [NR];

    function automatic logic [3:0] inc(input logic [3:0] p);
        return 4'((int'(p) + 1) % NR);
    endfunction

    // ---------------- monitor ----------------
    logic [7:0] last_tx;
    bit         hold_chk = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (hold_chk && !tx_valid) chk("tx_data_hold", tx_data, last_tx);
            hold_chk = 1'b0;
            if (ack_valid) begin
                if (ack_exp.size() == 0) fail_now("ack_unexpected");
                else begin
                    e = ack_exp.pop_front();
                    chk("ack_value", ack, e.val);
                    chk("ack_cycle", cyc, e.cyc);
                end
            end
            if (tx_valid) begin
                if (tx_exp.size() == 0) fail_now("tx_unexpected");
                else begin
                    e = tx_exp.pop_front();
                    chk("tx_data", tx_data, e.val);
                    chk("tx_cycle", cyc, e.cyc);
                    last_tx  = e.val;
                    hold_chk = 1'b1;
                end
            end
            if (loc_rvalid) begin
                if (loc_exp.size() == 0) fail_now("loc_rvalid_unexpected");
                else begin
                    e = loc_exp.pop_front();
                    chk("loc_rdata", loc_rdata, e.val);
                    chk("loc_rvalid_cycle", cyc, e.cyc);
                end
            end
            if (rf_we) we_seen++;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic i2c_start();
        @(posedge clk); #1 bus_start = 1'b1;
        @(posedge clk); #1 bus_start = 1'b0;
        mode = M_ADDR;
        repeat (2) @(posedge clk);
    endtask

    task automatic i2c_stop();
        @(posedge clk); #1 bus_stop = 1'b1;
        @(posedge clk); #1 bus_stop = 1'b0;
        mode = M_IDLE;
        repeat (2) @(posedge clk);
    endtask

    // Updates the model and returns the expected ACK bit for byte b.
    task automatic model_byte(input logic [7:0] b, output logic a);
        a = 1'b0;
        case (mode)
            M_ADDR: begin
                if (b[7:1] == 7'h2A) begin a = 1'b1; mode = b[0] ? M_RD : M_PTR; end
                else if (GC_EN && b == 8'h00) begin a = 1'b1; mode = M_GC; end
                else mode = M_IGN;
            end
            M_PTR: begin
                if (b < NR) begin a = 1'b1; mptr = b[3:0]; mode = M_WR; end
                else mode = M_IGN;
            end
            M_WR: begin a = 1'b1; gold[mptr] = b; mptr = inc(mptr); we_exp++; end
            M_GC: begin a = 1'b1; if (b == 8'h06) mptr = 4'd0; end
            default: a = 1'b0;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic a;
        model_byte(b, a);
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = b;
        ack_exp.push_back('{val: {7'b0, a}, cyc: cyc + 1});
        @(posedge clk); #1 rx_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic read_byte();
        logic [7:0] v;
        if (mode == M_RD) begin v = gold[mptr]; mptr = inc(mptr); end
        else v = 8'hFF;
        @(posedge clk); #1 tx_req = 1'b1;
        tx_exp.push_back('{val: v, cyc: cyc + 2});
        @(posedge clk); #1 tx_req = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // Caller is positioned just after a rising edge; request starts immediately.
    task automatic loc_access(input bit we, input logic [3:0] a, input logic [7:0] d, input int exp_wait);
        int  t0;
        int  gcyc;
        bit  granted;
        loc_req = 1'b1; loc_we = we; loc_addr = a; loc_wdata = d;
        t0 = cyc; granted = 1'b0; gcyc = 0;
        for (int i = 0; i < 20 && !granted; i++) begin
            @(negedge clk);
            if (loc_gnt) begin granted = 1'b1; gcyc = cyc; end
        end
        if (!granted) fail_now("loc_gnt_timeout");
        else begin
            chk("loc_gnt_latency", gcyc - t0, exp_wait);
            if (we) begin gold[a] = d; we_exp++; end
            else loc_exp.push_back('{val: gold[a], cyc: gcyc + 1});
        end
        @(posedge clk); #1 loc_req = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ack_valid"}, ack_valid, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_rf_re"}, rf_re, 0);
        chk({tag, "_rf_addr"}, rf_addr, 0);
        chk({tag, "_rf_wdata"}, rf_wdata, 0);
        chk({tag, "_loc_gnt"}, loc_gnt, 0);
        chk({tag, "_loc_rvalid"}, loc_rvalid, 0);
        chk({tag, "_loc_rdata"}, loc_rdata, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [7:0] ab, pb;
        int         n, kind;

        repeat (3) @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Preload every register through the local port.
        for (int i = 0; i < NR; i++) begin
            @(posedge clk); #1 loc_access(1'b1, 4'(i), 8'($urandom), 0);
        end

        // Directed write: 4 ACKs, reg3=A5, reg4=5A, pointer=5.
        i2c_start(); send_byte(8'h54); send_byte(8'h03); send_byte(8'hA5); send_byte(8'h5A); i2c_stop();
        i2c_start(); send_byte(8'h55); read_byte(); i2c_stop();

        // Repeated-START read with wrap 15 -> 0 -> 1.
        i2c_start(); send_byte(8'h54); send_byte(8'h0F);
        i2c_start(); send_byte(8'h55); read_byte(); read_byte(); read_byte(); i2c_stop();

        // Wrong address, then data; out-of-range pointer.
        i2c_start(); send_byte(8'h40); send_byte(8'h12); read_byte(); i2c_stop();
        i2c_start(); send_byte(8'h54); send_byte(8'h10); send_byte(8'h99); i2c_stop();
        i2c_start(); send_byte(8'h55); read_byte(); i2c_stop();

        // Local write collides with an I2C rf_we: grant one cycle late, both land.
        i2c_start(); send_byte(8'h54); send_byte(8'h06);
        begin
            logic a;
            model_byte(8'h11, a);
            @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h11;
            ack_exp.push_back('{val: {7'b0, a}, cyc: cyc + 1});
            @(posedge clk); #1 rx_valid = 1'b0;
            loc_access(1'b1, 4'd7, 8'h3C, 1);
        end
        repeat (3) @(posedge clk);
        i2c_stop();
        i2c_start(); send_byte(8'h54); send_byte(8'h06);
        i2c_start(); send_byte(8'h55); read_byte(); read_byte(); i2c_stop();
        @(posedge clk); #1 loc_access(1'b0, 4'd7, 8'h00, 0);

        // Reset between rx_valid and the would-be rf_we.
        i2c_start(); send_byte(8'h54); send_byte(8'h02);
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h77;
        #3 rst = 1'b1;
        @(negedge clk); chk_quiet("midrst");
        @(posedge clk); #1 rx_valid = 1'b0;
        @(negedge clk); chk_quiet("midrst2");
        @(posedge clk); #1 rst = 1'b0;
        mode = M_IDLE; mptr = 4'd0;
        i2c_start(); send_byte(8'h55); read_byte(); i2c_stop();

        // General call: ACKed and pointer cleared when enabled, NACKed otherwise.
        i2c_start(); send_byte(8'h54); send_byte(8'h09); i2c_stop();
        i2c_start(); send_byte(8'h00); send_byte(8'h06); i2c_stop();
        i2c_start(); send_byte(8'h55); read_byte(); i2c_stop();

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 4);
            n    = $urandom_range(1, 4);
            case (kind)
                0: begin
                    ab = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h54;
                    pb = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
                    i2c_start(); send_byte(ab); send_byte(pb);
                    for (int k = 0; k < n; k++) send_byte(8'($urandom));
                    i2c_stop();
                end
                1: begin
                    i2c_start();
                    if ($urandom_range(0, 1) == 1) begin
                        send_byte(8'h54); send_byte(8'($urandom_range(0, 15)));
                        i2c_start();
                    end
                    send_byte(($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h55);
                    for (int k = 0; k < n; k++) read_byte();
                    i2c_stop();
                end
                2: begin @(posedge clk); #1 loc_access(1'b1, 4'($urandom), 8'($urandom), 0); end
                3: begin @(posedge clk); #1 loc_access(1'b0, 4'($urandom), 8'h00, 0); end
                default: begin send_byte(8'($urandom)); read_byte(); end
            endcase
        end

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("ack_queue_drained", ack_exp.size(), 0);
        chk("tx_queue_drained", tx_exp.size(), 0);
        chk("loc_queue_drained", loc_exp.size(), 0);
        chk("rf_we_count", we_seen, we_exp);
        for (int i = 0; i < NR; i++) chk($sformatf("reg%0d", i), mem[i], gold[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
Transaction controller between the I2C slave byte engine and the on-chip register file.
- Decodes the address/RW byte, then the register-pointer byte.
- Sequences register writes and reads with pointer auto-increment, and drives per-byte ACK/NACK.
- Arbitrates register-file access between the I2C side and a local (chip-side) requester.

Parameters:
NUM_REGS, 16, number of 8-bit registers; pointer width PW = clog2(NUM_REGS).
DEV_ADDR, 7'h2A, 7-bit device address this slave answers to.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
bus_start  in  1  one-cycle pulse: START or repeated START seen
bus_stop  in  1  one-cycle pulse: STOP seen
rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
rx_data  in  8  received byte
ack_valid  out  1  one-cycle pulse, exactly 1 cycle after rx_valid
ack  out  1  1=ACK, 0=NACK; meaningful while ack_valid
tx_req  in  1  one-cycle pulse: engine needs the next read byte
tx_valid  out  1  one-cycle pulse, exactly 2 cycles after tx_req
tx_data  out  8  byte to transmit; held until next tx_valid
rf_addr  out  PW  register-file address
rf_we  out  1  register-file write strobe
rf_re  out  1  register-file read strobe; rf_rdata valid next cycle
rf_wdata  out  8  register-file write data
rf_rdata  in  8  register-file read data
loc_req  in  1  local access request; held until loc_gnt
loc_we  in  1  local access is a write
loc_addr  in  PW  local address
loc_wdata  in  8  local write data
loc_gnt  out  1  one-cycle grant pulse
loc_rvalid  out  1  pulse 1 cycle after a granted local read; data on loc_rdata
loc_rdata  out  8  local read data

Behaviour:
- Reset: state IDLE, pointer 0. ack_valid, ack, tx_valid, rf_we, rf_re, loc_gnt and loc_rvalid are 0. tx_data, rf_addr, rf_wdata and loc_rdata are 0.
- State machine: IDLE, ADDR, PTR, WR, RD, IGNORE.
  - bus_start in any state -> ADDR. Pointer is kept, so a repeated-START read continues from the pointer.
  - bus_stop in any state -> IDLE.
  - rst mid-transaction aborts immediately; no rf_we is issued.
- ADDR on rx_valid:
  - rx_data[7:1]==DEV_ADDR: ACK. rx_data[0]=0 -> PTR; rx_data[0]=1 -> RD.
  - otherwise: NACK -> IGNORE.
- PTR on rx_valid:
  - rx_data<NUM_REGS: pointer=rx_data, ACK -> WR.
  - rx_data>=NUM_REGS: NACK, pointer unchanged -> IGNORE.
- WR on rx_valid:
  - rf_we=1, rf_addr=pointer, rf_wdata=rx_data in the cycle after rx_valid (same cycle as ack_valid); ACK.
  - pointer increments, NUM_REGS-1 wraps to 0.
- RD on tx_req:
  - cycle+1: rf_re=1, rf_addr=pointer.
  - cycle+2: tx_data=rf_rdata, tx_valid=1; pointer increments with wrap.
- IGNORE: rx_valid -> NACK; tx_req -> tx_valid with tx_data=8'hFF. Pointer untouched.
- rx_valid or tx_req received in IDLE: same as IGNORE.
- Arbitration:
  - The I2C side owns the register file in any cycle where it drives rf_we or rf_re.
  - Otherwise a pending loc_req is granted: loc_gnt=1 that cycle and rf_* driven from loc_*.
  - Simultaneous I2C access and loc_req: I2C wins, loc_gnt stays 0, and the requester keeps loc_req high.
  - Local read data is returned on loc_rdata with loc_rvalid 1 cycle after loc_gnt.
  - Local accesses never change the pointer.
- Back-to-back rx_valid on consecutive cycles is not supported; the engine guarantees ≥3 cycles between events.

Optional Feature:
I2C_GENERAL_CALL_EN
- Defined:
  - address byte 8'h00 is ACKed -> state GCALL.
  - In GCALL every data byte is ACKed; byte 8'h06 resets the pointer to 0; all other bytes are discarded.
  - No register-file writes in GCALL.
- Undefined: 8'h00 is NACKed like any non-matching address; GCALL does not exist.

Decomposition:
- Package i2c_pkg: state enum (IDLE, ADDR, PTR, WR, RD, IGNORE, GCALL), ACK/NACK constants, GCALL_RESET_CMD=8'h06, IDLE_TX_BYTE=8'hFF.
- Sub-module i2c_rf_arbiter: fixed-priority mux of the I2C and local requests onto rf_*, generating loc_gnt and loc_rvalid.

Test Plan:
- Write: START, 8'h54, 8'h03, 8'hA5, 8'h5A, STOP -> 4 ACKs; reg3=A5, reg4=5A; pointer=5.
- Read with repeated START: write pointer 8'h0F, repeated START, 8'h55, 3×tx_req -> tx_data = reg15, reg0, reg1 (wrap); each tx_valid exactly 2 cycles after its tx_req.
- Wrong address 8'h40, then 8'h12 -> both NACKed; no rf_we. Pointer byte 8'h10 -> NACK, pointer unchanged.
- Arbitration: loc_req write reg7=8'h3C asserted in the same cycle as an I2C rf_we -> grant deferred 1 cycle; both writes land.
- Reset mid-write: rst between rx_valid and rf_we -> no write; all outputs 0. With I2C_GENERAL_CALL_EN: 8'h00 then 8'h06 -> both ACKed, pointer=0.
